cordic_angle_reducer: RTL and testbench

Front-end stage for the 16-iteration CORDIC sine/cosine core. Accepts an arbitrary angle in [-4, 4) rad via a valid/ready handshake and folds it into the core's convergence range [-π/2, π/2]. It then drives the core's start/done handshake, applies the quadrant sign correction to the returned cos/sin, and presents the final result on a valid/ready output port.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/cordic_quadrant_map.sv | 28 ++
 rtl/cordic_angle_reducer.sv | 141 ++++++++++++++
 tb/tb_cordic_angle_reducer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, FSM state encoding and saturating negate for the CORDIC angle reducer.
package cordic_pkg;

  localparam int ANG_W = 17;
  localparam int Q14_W = 16;

  localparam logic signed [ANG_W-1:0] PI      = 17'sd25736;
  localparam logic signed [ANG_W-1:0] HALF_PI = 17'sd12868;
  localparam logic signed [ANG_W-1:0] TWO_PI  = 17'sd51472;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REDUCE = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  // -32768 has no positive twin in 16 bits, so it clamps to +32767.
  function automatic logic signed [Q14_W-1:0] sat_neg(input logic signed [Q14_W-1:0] v);
    return (v == 16'sh8000) ? 16'sh7fff : -v;
  endfunction

endpackage

// File: rtl/cordic_quadrant_map.sv
// Folds a Q3.13 angle in [-4,4) into [-pi/2, pi/2]; returns it as Q2.14 plus a negate flag.
module cordic_quadrant_map
  import cordic_pkg::*;
(
  input  logic signed [ANG_W-1:0] i_angle,
  output logic        [Q14_W-1:0] o_angle,
  output logic                    o_neg
);

  logic signed [ANG_W-1:0] w_a;

  always_comb begin
    w_a   = i_angle;
    o_neg = 1'b0;
    if (w_a >= PI) w_a = w_a - TWO_PI;
    if (w_a < -PI) w_a = w_a + TWO_PI;
    // Exactly +/-HALF_PI is left alone; exactly PI lands here as -PI and folds to 0.
    if (w_a > HALF_PI) begin
      w_a   = w_a - PI;
      o_neg = 1'b1;
    end else if (w_a < -HALF_PI) begin
      w_a   = w_a + PI;
      o_neg = 1'b1;
    end
    o_angle = Q14_W'(w_a <<< 1);
  end

endmodule

// File: rtl/cordic_angle_reducer.sv
// Angle reducer front-end for the CORDIC sin/cos core: fold, start core, sign-correct, present.
// Optional watchdog on the core handshake: define CORDIC_ANGLE_RED_WATCHDOG_EN.
module cordic_angle_reducer
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 16
`ifdef CORDIC_ANGLE_RED_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYCLES = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] angle_in,
  output logic                  cordic_start,
  output logic [DATA_WIDTH-1:0] cordic_angle,
  input  logic [DATA_WIDTH-1:0] cordic_x,
  input  logic [DATA_WIDTH-1:0] cordic_y,
  input  logic                  cordic_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] cos_out,
  output logic [DATA_WIDTH-1:0] sin_out,
  output logic                  err_out,
  output state_t                dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid holds its payload stable until then, and in_ready/out_valid are never high together.

  state_t                  r_state;
  logic                    r_in_ready;
  logic signed [DATA_WIDTH:0] r_angle;
  logic [DATA_WIDTH-1:0]   r_cordic_angle;
  logic                    r_start;
  logic                    r_neg;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_cos;
  logic [DATA_WIDTH-1:0]   r_sin;
  logic [DATA_WIDTH-1:0]   w_red_angle;
  logic                    w_red_neg;

`ifdef CORDIC_ANGLE_RED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;
`endif

  cordic_quadrant_map u_map (
    .i_angle (r_angle),
    .o_angle (w_red_angle),
    .o_neg   (w_red_neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_in_ready     <= 1'b0;
      r_angle        <= '0;
      r_cordic_angle <= '0;
      r_start        <= 1'b0;
      r_neg          <= 1'b0;
      r_out_valid    <= 1'b0;
      r_cos          <= '0;
      r_sin          <= '0;
`ifdef CORDIC_ANGLE_RED_WATCHDOG_EN
      r_wd_cnt       <= '0;
      r_err          <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // in_ready comes up one cycle after reset release, then stays up while idle.
          if (r_in_ready && in_valid) begin
            r_angle    <= {angle_in[DATA_WIDTH-1], angle_in};
            r_in_ready <= 1'b0;
            r_state    <= S_REDUCE;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_REDUCE: begin
          r_cordic_angle <= w_red_angle;
          r_neg          <= w_red_neg;
          r_start        <= 1'b1;
          r_state        <= S_START;
        end
        S_START: begin
`ifdef CORDIC_ANGLE_RED_WATCHDOG_EN
          r_wd_cnt <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (cordic_done) begin
            r_cos       <= r_neg ? sat_neg(cordic_x) : cordic_x;
            r_sin       <= r_neg ? sat_neg(cordic_y) : cordic_y;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
`ifdef CORDIC_ANGLE_RED_WATCHDOG_EN
            r_err       <= 1'b0;
          end else if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            r_cos       <= '0;
            r_sin       <= '0;
            r_err       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
`endif
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign cordic_start = r_start;
  assign cordic_angle = r_cordic_angle;
  assign out_valid    = r_out_valid;
  assign cos_out      = r_cos;
  assign sin_out      = r_sin;
  assign dbg_state    = r_state;
`ifdef CORDIC_ANGLE_RED_WATCHDOG_EN
  assign err_out      = r_err;
`else
  assign err_out      = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_angle_reducer.sv
// Directed + random bench for cordic_angle_reducer with a behavioural CORDIC core responder.
module tb_cordic_angle_reducer;
  import cordic_pkg::*;

  localparam int W  = 16;
  localparam int TO = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  angle_in;
  logic          cordic_start;
  logic [W-1:0]  cordic_angle;
  logic [W-1:0]  cordic_x;
  logic [W-1:0]  cordic_y;
  logic          cordic_done;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  cos_out;
  logic [W-1:0]  sin_out;
  logic          err_out;
  state_t        dbg_state;

  logic [2*W:0]  exp_q[$];      // {err, cos, sin}
  logic [W-1:0]  exp_ang_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  cordic_angle_reducer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .angle_in     (angle_in),
    .cordic_start (cordic_start),
    .cordic_angle (cordic_angle),
    .cordic_x     (cordic_x),
    .cordic_y     (cordic_y),
    .cordic_done  (cordic_done),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .cos_out      (cos_out),
    .sin_out      (sin_out),
    .err_out      (err_out),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // independent folding model for random stimulus
  task automatic ref_reduce(input int a, output logic [W-1:0] ang, output bit neg);
    int r;
    r   = a;
    neg = 1'b0;
    if (r >= 25736) r = r - 51472;
    if (r < -25736) r = r + 51472;
    if (r > 12868) begin
      r = r - 25736; neg = 1'b1;
    end else if (r < -12868) begin
      r = r + 25736; neg = 1'b1;
    end
    ang = 16'(r * 2);
  endtask

  function automatic int fix_sign(input int v, input bit neg);
    if (!neg) return v;
    return (v == -32768) ? 32767 : -v;
  endfunction

  // driver tasks
  task automatic send_angle(input logic [W-1:0] ang);
    int t;
    t = 0;
    @(negedge clk);
    angle_in = ang;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", 64'(t < 40), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    angle_in = 16'($urandom);
  endtask

  task automatic core_respond(input int dly, input logic [W-1:0] x, input logic [W-1:0] y,
                              input bit give_done, input bit early);
    int t;
    t = 0;
    while (cordic_start !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("start_wait", 64'(t < 40), 64'd1);
    check("cordic_angle", 64'(cordic_angle), 64'(exp_ang_q.pop_front()));
    if (give_done) begin
      if (early) begin
        // done during START must be ignored
        cordic_x = 16'h0707; cordic_y = 16'h0707; cordic_done = 1'b1;
        @(negedge clk);
        cordic_done = 1'b0;
      end
      repeat (dly) @(negedge clk);
      cordic_x = x; cordic_y = y; cordic_done = 1'b1;
      @(negedge clk);
      cordic_done = 1'b0;
      cordic_x = 16'($urandom);
      cordic_y = 16'($urandom);
    end
  endtask

  task automatic recv(input int hold);
    int t;
    logic [2*W:0] exp;
    logic [2*W:0] snap;
    t = 0;
    while (out_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("out_wait", 64'(t < 100), 64'd1);
    exp = exp_q.pop_front();
    check("in_ready_excl", 64'(in_ready), 64'd0);
    snap = {err_out, cos_out, sin_out};
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_stable", 64'({out_valid, in_ready, err_out, cos_out, sin_out}),
            64'({2'b10, snap}));
    end
    check("result", 64'({err_out, cos_out, sin_out}), 64'(exp));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_back", 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  task automatic run_txn(input int ang, input int x, input int y, input int e_ang,
                         input int e_cos, input int e_sin, input int dly, input int hold,
                         input bit early);
    exp_ang_q.push_back(16'(e_ang));
    exp_q.push_back({1'b0, 16'(e_cos), 16'(e_sin)});
    send_angle(16'(ang));
    core_respond(dly, 16'(x), 16'(y), 1'b1, early);
    recv(hold);
  endtask

  int t_ang[9] = '{0, 25736, 19302, 30000, 12868, -12868, -25736, -32768, 32767};
  int t_x[9]   = '{16384, 16384, 11585, -32768, 0, 0, 16384, 1000, 5};
  int t_y[9]   = '{0, 0, -11585, 100, 16384, -16384, 0, -2000, -5};
  int t_ea[9]  = '{0, 0, -12868, 8528, 25736, -25736, 0, -14064, 14062};
  int t_ec[9]  = '{16384, -16384, -11585, 32767, 0, 0, -16384, -1000, -5};
  int t_es[9]  = '{0, 0, 11585, -100, 16384, -16384, 0, 2000, 5};

  initial begin
    int ra, rx, ry;
    logic [W-1:0] e_ang;
    bit e_neg;
    int cnt;

    rst_n = 1'b0; in_valid = 1'b0; angle_in = '0; cordic_x = '0; cordic_y = '0;
    cordic_done = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({in_ready, cordic_start, cordic_angle, out_valid, cos_out, sin_out, err_out}),
          64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("in_ready_after_rst", 64'({in_ready, out_valid}), 64'(2'b10));

    // directed table: folding boundaries and saturation
    for (int i = 0; i < 9; i++)
      run_txn(t_ang[i], t_x[i], t_y[i], t_ea[i], t_ec[i], t_es[i], 1 + (i % 3), 0, (i == 2));

    // random angles against the folding model
    for (int i = 0; i < 6; i++) begin
      ra = int'($signed(16'($urandom_range(0, 65535))));
      rx = int'($signed(16'($urandom_range(0, 65535))));
      ry = int'($signed(16'($urandom_range(0, 65535))));
      ref_reduce(ra, e_ang, e_neg);
      run_txn(ra, rx, ry, int'($signed(e_ang)), fix_sign(rx, e_neg), fix_sign(ry, e_neg),
              $urandom_range(1, 5), 0, 1'b0);
    end

    // consumer back-pressure for 10 cycles
    run_txn(19302, 11585, -11585, -12868, -11585, 11585, 2, 10, 1'b0);

    // reset while waiting on the core, then a stale done
    exp_ang_q.push_back(16'd8528);
    send_angle(16'd30000);
    core_respond(0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wait", 64'({in_ready, cordic_start, cordic_angle, out_valid, cos_out, sin_out, err_out}),
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cordic_x = 16'h1234; cordic_y = 16'h4321; cordic_done = 1'b1;
    @(negedge clk);
    cordic_done = 1'b0;
    @(negedge clk);
    check("stale_done_ignored", 64'({in_ready, out_valid, cos_out, sin_out}), 64'({2'b10, 32'd0}));
    run_txn(25736, 16384, 0, 0, -16384, 0, 3, 0, 1'b0);

`ifdef CORDIC_ANGLE_RED_WATCHDOG_EN
    // core never answers: watchdog completes with err_out
    exp_ang_q.push_back(16'd0);
    send_angle(16'd0);
    core_respond(0, '0, '0, 1'b0, 1'b0);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("wd_latency", 64'(cnt), 64'(TO + 1));
    check("wd_result", 64'({err_out, cos_out, sin_out}), 64'({1'b1, 32'd0}));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    run_txn(0, 16384, 0, 0, 16384, 0, 1, 0, 1'b0);
`else
    cnt = 0;
`endif

    check("queues_empty", 64'(exp_q.size() + exp_ang_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
